// File: rtl/st7066u_init_sequencer.sv
// ST7066U 8-bit power-on init sequencer: walks the command ROM with datasheet timing, then passes the runtime bus through.
// Build option: define ST7066U_INIT_CURSOR_EN to turn cursor and blink on in the display-on command.
module st7066u_init_sequencer #(
  parameter int POWERUP_CYCLES    = 4000000,
  parameter int E_PULSE_CYCLES    = 50,
  parameter int CMD_WAIT_CYCLES   = 4000,
  parameter int CLEAR_WAIT_CYCLES = 160000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ena,
  input  logic       i_update_pulse,
  input  logic       i_rs,
  input  logic       i_e,
  input  logic [7:0] i_d,
  output logic       o_rs,
  output logic       o_e,
  output logic [7:0] o_d,
  output logic       o_ready,
  output logic       o_update_pulse
);

  localparam int MAX_A = (POWERUP_CYCLES > E_PULSE_CYCLES) ? POWERUP_CYCLES : E_PULSE_CYCLES;
  localparam int MAX_B = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYCLES - 1);

  localparam logic [2:0] S_PWR_WAIT = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_E_HIGH   = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [2:0] IDX_CLEAR = 3'd3;
  localparam logic [2:0] IDX_LAST  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic [7:0]       d_q, d_d;
  logic             ready_q, ready_d;
  logic             upd_q, upd_d;
  logic [CNT_W-1:0] wait_last;

  function automatic logic [7:0] cmd_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_rom = 8'h38;
      3'd1:    cmd_rom = 8'h38;
`ifdef ST7066U_INIT_CURSOR_EN
      3'd2:    cmd_rom = 8'h0F;
`else
      3'd2:    cmd_rom = 8'h0C;
`endif
      3'd3:    cmd_rom = 8'h01;
      3'd4:    cmd_rom = 8'h06;
      default: cmd_rom = 8'h00;
    endcase
  endfunction

  // Clear display needs the long settle time; everything else uses the short one.
  assign wait_last = (idx_q == IDX_CLEAR) ? CLEAR_LAST : CMD_LAST;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    pending_d = pending_q | i_update_pulse;
    rs_d      = rs_q;
    e_d       = e_q;
    d_d       = d_q;
    ready_d   = ready_q;
    upd_d     = 1'b0;
    case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          rs_d    = 1'b0;
          d_d     = cmd_rom(idx_q);
        end
      end
      S_SETUP: begin
        state_d = S_E_HIGH;
        cnt_d   = '0;
        e_d     = 1'b1;
      end
      S_E_HIGH: begin
        if (cnt_q == E_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          e_d     = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            idx_d   = idx_q + 3'd1;
            rs_d    = 1'b0;
            d_d     = cmd_rom(idx_q + 3'd1);
          end
        end
      end
      S_DONE: begin
        // pending can only be set before DONE, so it flushes on the first DONE cycle only.
        cnt_d     = cnt_q;
        rs_d      = i_rs;
        e_d       = i_e;
        d_d       = i_d;
        ready_d   = 1'b1;
        upd_d     = i_update_pulse | pending_q;
        pending_d = 1'b0;
      end
      default: begin
        state_d = S_PWR_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_PWR_WAIT;
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      rs_q      <= 1'b0;
      e_q       <= 1'b0;
      d_q       <= 8'h00;
      ready_q   <= 1'b0;
      upd_q     <= 1'b0;
    end else if (i_ena) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      rs_q      <= rs_d;
      e_q       <= e_d;
      d_q       <= d_d;
      ready_q   <= ready_d;
      upd_q     <= upd_d;
    end
  end

  assign o_rs           = rs_q;
  assign o_e            = e_q;
  assign o_d            = d_q;
  assign o_ready        = ready_q;
  assign o_update_pulse = upd_q;

endmodule

// File: tb/tb_st7066u_init_sequencer.sv
// Scoreboard bench for st7066u_init_sequencer: a timeline model predicts every E pulse, ready rise and update pulse.
module tb_st7066u_init_sequencer;
  localparam int PWR = 20;
  localparam int EP  = 3;
  localparam int CW  = 10;
  localparam int CLW = 30;
  localparam int PW  = 41;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1, ena_i = 1'b1, upd_i = 1'b0, rs_i = 1'b0, e_i = 1'b0;
  logic [7:0] d_i = 8'h00;
  logic       rs_o, e_o, ready_o, upd_o;
  logic [7:0] d_o;

  int now = 0;
  int n_vec = 0;
  int n_miss = 0;

  // Expected events: E pulses {rise, fall, rs, d}, ready rise times, update pulse times, passthrough {time, rs, e, d}.
  logic [PW-1:0] pulse_q[$];
  logic [15:0]   ready_q[$];
  logic [15:0]   upd_q[$];
  logic [25:0]   pass_q[$];
  logic [7:0]    rom [5];

  st7066u_init_sequencer #(
    .POWERUP_CYCLES(PWR), .E_PULSE_CYCLES(EP), .CMD_WAIT_CYCLES(CW), .CLEAR_WAIT_CYCLES(CLW)
  ) dut (
    .i_clk(clk), .i_reset(rst_i), .i_ena(ena_i), .i_update_pulse(upd_i),
    .i_rs(rs_i), .i_e(e_i), .i_d(d_i),
    .o_rs(rs_o), .o_e(e_o), .o_d(d_o), .o_ready(ready_o), .o_update_pulse(upd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) now <= now + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, now, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_o_e"}, 64'(e_o), 64'd0);
    check({tag, "_o_rs"}, 64'(rs_o), 64'd0);
    check({tag, "_o_d"}, 64'(d_o), 64'd0);
    check({tag, "_o_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_o_update_pulse"}, 64'(upd_o), 64'd0);
  endtask

  function automatic int shifted(input int x, input int p_at, input int p_len);
    return (p_len > 0 && x > p_at) ? x + p_len : x;
  endfunction

  // Timeline model: command i rises at rel+PWR+1 plus the durations of earlier commands; a pause
  // pushes every later edge back, and a reset cuts the pulse in flight.
  task automatic push_seq(input int rel, input int p_at, input int p_len, input int cut, output int t_ready);
    int t, r, f;
    t = rel + PWR + 1;
    t_ready = -1;
    for (int i = 0; i < 5; i++) begin
      r = shifted(t, p_at, p_len);
      f = shifted(t + EP, p_at, p_len);
      if (cut >= 0 && r >= cut) return;
      if (cut >= 0 && f > cut) f = cut;
      pulse_q.push_back({r[15:0], f[15:0], 1'b0, rom[i]});
      t += 1 + EP + ((i == 3) ? CLW : CW);
    end
    if (cut < 0) begin
      t_ready = shifted(t, p_at, p_len);
      ready_q.push_back(t_ready[15:0]);
    end
  endtask

  task automatic run_seq(input int p_len, input bit do_cut, output int tr);
    int rel, p_at, cut, t_end, lo;
    int pul[3];
    rel  = now;
    p_at = (p_len > 0) ? rel + PWR + 2 : -1;
    cut  = do_cut ? rel + PWR + 1 + 3 * (1 + EP + CW) + 2 : -1;
    push_seq(rel, p_at, p_len, cut, tr);
    if (do_cut) begin
      pul[0] = int'($urandom_range(rel + 1, cut - 2));
      pul[1] = -1;
      pul[2] = -1;
      t_end  = cut;
    end else begin
      pul[0] = (p_len > 0) ? int'($urandom_range(rel + 1, p_at - 1)) : int'($urandom_range(rel + 1, rel + PWR));
      lo     = (p_len > 0) ? p_at + p_len : rel + PWR;
      pul[1] = int'($urandom_range(lo, tr - 2));
      pul[2] = tr - 1;
      upd_q.push_back(tr[15:0]);
      t_end  = tr;
    end
    rst_i = 1'b0;
    while (1) begin
      ena_i = !(p_len > 0 && now >= p_at && now < p_at + p_len);
      upd_i = (now == pul[0]) || (now == pul[1]) || (now == pul[2]);
      if (do_cut && now == cut - 1) rst_i = 1'b1;
      if (now >= t_end) break;
      @(negedge clk);
    end
  endtask

  task automatic run_done();
    logic [9:0] prev, expv;
    logic       prev_u, eu, en, u, rs, e;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    upd_i = 1'b1;
    upd_q.push_back(16'(now + 1));
    @(negedge clk);
    upd_i = 1'b0;
    repeat (2) @(negedge clk);
    prev   = '0;
    prev_u = 1'b0;
    for (int k = 0; k < 40; k++) begin
      en = ($urandom_range(0, 3) != 0);
      rs = 1'($urandom_range(0, 1));
      e  = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      u  = ($urandom_range(0, 3) == 0);
      if (k == 0) begin
        en = 1'b1; rs = 1'b1; e = 1'b1; d = 8'hA5;
      end
      ena_i = en; rs_i = rs; e_i = e; d_i = d; upd_i = u;
      expv = en ? {rs, e, d} : prev;
      pass_q.push_back({16'(now + 1), expv});
      eu = en ? u : prev_u;
      if (eu) upd_q.push_back(16'(now + 1));
      prev   = expv;
      prev_u = eu;
      @(negedge clk);
    end
    ena_i = 1'b1; rs_i = 1'b0; e_i = 1'b0; d_i = 8'h00; upd_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic       e_prev = 1'b0, ready_prev = 1'b0, trk = 1'b0, rs_r = 1'b0;
  logic [7:0] d_prev = 8'h00, d_hold = 8'h00, d_setup = 8'h00;
  int         rise_t = 0;
  always @(negedge clk) begin
    logic [PW-1:0] ex;
    logic [15:0]   ex_t;
    logic [25:0]   ex_p;
    if (!ready_o && e_o === 1'b1 && !e_prev) begin
      trk = 1'b1; rise_t = now; d_setup = d_prev; rs_r = rs_o;
    end
    if (trk && e_o) d_hold = d_o;
    if (trk && !e_o) begin
      trk = 1'b0;
      check("e_pulse_expected", 64'(pulse_q.size() != 0), 64'd1);
      if (pulse_q.size() != 0) begin
        ex = pulse_q.pop_front();
        check("e_pulse", 64'({16'(rise_t), 16'(now), rs_r, d_hold}), 64'(ex));
        check("e_setup_d", 64'(d_setup), 64'(ex[7:0]));
      end
    end
    if (ready_o === 1'b1 && !ready_prev) begin
      check("ready_expected", 64'(ready_q.size() != 0), 64'd1);
      if (ready_q.size() != 0) begin
        ex_t = ready_q.pop_front();
        check("ready_rise", 64'(now), 64'(ex_t));
      end
    end
    if (upd_o === 1'b1) begin
      check("update_expected", 64'(upd_q.size() != 0), 64'd1);
      if (upd_q.size() != 0) begin
        ex_t = upd_q.pop_front();
        check("update_pulse", 64'(now), 64'(ex_t));
      end
    end
    if (pass_q.size() != 0 && pass_q[0][25:10] == 16'(now)) begin
      ex_p = pass_q.pop_front();
      check("passthrough", 64'({rs_o, e_o, d_o}), 64'(ex_p[9:0]));
    end
    e_prev     = (e_o === 1'b1);
    ready_prev = (ready_o === 1'b1);
    d_prev     = d_o;
  end

  initial begin
    int tr;
    rom[0] = 8'h38;
    rom[1] = 8'h38;
`ifdef ST7066U_INIT_CURSOR_EN
    rom[2] = 8'h0F;
`else
    rom[2] = 8'h0C;
`endif
    rom[3] = 8'h01;
    rom[4] = 8'h06;
    repeat (3) @(negedge clk);
    check_reset("init");
    run_seq(50, 1'b0, tr);
    run_done();
    check_reset("done_reset");
    run_seq(0, 1'b1, tr);
    check_reset("mid_e_reset");
    run_seq(0, 1'b0, tr);
    run_done();
    check_reset("final_reset");
    repeat (5) @(negedge clk);
    check("e_pulses_left", 64'(pulse_q.size()), 64'd0);
    check("ready_left", 64'(ready_q.size()), 64'd0);
    check("updates_left", 64'(upd_q.size()), 64'd0);
    check("passthrough_left", 64'(pass_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout, expected completion", now);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/st7066u_init_sequencer.md
Name: st7066u_init_sequencer

Overview:
- Power-on initialisation and bus-ownership controller for the ST7066U LCD in 8-bit mode.
- After reset it waits for LCD power-up, then issues the fixed command sequence with datasheet timing.
- It then hands the rs/e/d bus to the runtime write path and releases any time-update pulses it held back during init.
- Sits between the runtime LCD write path (rs/e/d sources, update-pulse generator) and the board pins.

Parameters:
- POWERUP_CYCLES, 4000000, idle cycles after reset before the first command (40 ms at 100 MHz)
- E_PULSE_CYCLES, 50, cycles o_e is held high per command (500 ns)
- CMD_WAIT_CYCLES, 4000, post-strobe wait for normal commands (40 us)
- CLEAR_WAIT_CYCLES, 160000, post-strobe wait after clear display (1.6 ms)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_ena  in  1  clock enable; when low, all state, counters and outputs hold
- i_update_pulse  in  1  single-cycle request from the update-pulse generator
- i_rs  in  1  runtime register select
- i_e  in  1  runtime enable strobe
- i_d  in  8  runtime data bus
- o_rs  out  1  LCD RS pin
- o_e  out  1  LCD E pin
- o_d  out  8  LCD data pins
- o_ready  out  1  high once init is complete and the runtime path owns the bus
- o_update_pulse  out  1  gated or deferred update pulse to the control FSM

Behaviour:
- All outputs are registered. Reset values: o_rs=0, o_e=0, o_d=8'h00, o_ready=0, o_update_pulse=0; state=PWR_WAIT, cmd index=0, pending=0.
- Command ROM, issued in order (index 0..4), all with rs=0: 8'h38 function set, 8'h38 function set, 8'h0C display on, 8'h01 clear, 8'h06 entry mode.
- States:
  - PWR_WAIT: count POWERUP_CYCLES, then go to SETUP.
  - SETUP: drive o_d=ROM[idx] and o_rs=0 with o_e=0 for 1 cycle (address setup), then go to E_HIGH.
  - E_HIGH: o_e=1 for E_PULSE_CYCLES, then o_e=0 and go to WAIT.
  - WAIT: count CLEAR_WAIT_CYCLES if idx==3, else CMD_WAIT_CYCLES. At the end, if idx==4 go to DONE; otherwise idx+1 and go to SETUP.
  - DONE: terminal state until reset. o_ready=1. o_rs/o_e/o_d register i_rs/i_e/i_d, giving 1-cycle latency.
- o_d holds the current command through E_HIGH and WAIT; it is not cleared between commands.
- Per-command duration: 1 + E_PULSE_CYCLES + wait cycles.
- Counters are sized from the largest parameter. Each counter is cleared on state entry; no wrap occurs.
- Update-pulse gating:
  - Before DONE, i_update_pulse sets pending; multiple pulses collapse to one.
  - In DONE, o_update_pulse is i_update_pulse registered (1-cycle latency).
  - On the first DONE cycle, o_update_pulse=1 if pending (or if i_update_pulse was high in the previous cycle), then pending clears. A simultaneous pending flush and new pulse yields exactly one pulse.
- i_ena low: nothing advances, including pending capture and the DONE passthrough register; outputs hold their values.
- i_reset mid-operation (including during E_HIGH): next cycle all outputs take reset values (o_e drops immediately), state=PWR_WAIT, full sequence restarts, pending cleared.
- i_reset has priority over i_ena.

Optional Feature:
- ST7066U_INIT_CURSOR_EN
  - Defined: ROM[2] = 8'h0F (display, cursor and blink on), for debug of write positioning.
  - Undefined: ROM[2] = 8'h0C.
  - No other timing or behaviour changes.

Test Plan:
- All tests use POWERUP=20, E_PULSE=3, CMD_WAIT=10, CLEAR_WAIT=30.
- Reset release at cycle 0 -> first o_e rise at cycle 21 with o_d=8'h38, o_rs=0; o_e high exactly 3 cycles.
- Full sequence -> o_e pulses carry 38,38,0C,01,06; gap between clear falling edge and next rising edge = 31 cycles; o_ready rises 11 cycles after the last o_e fall.
- Three i_update_pulse during init -> exactly one o_update_pulse, on the first cycle o_ready=1; pulse in DONE -> output one cycle later.
- i_ena held low 50 cycles mid-E_HIGH -> o_e stays high, and all later edges shift by exactly 50 cycles.
- i_reset asserted during the 4th command's E_HIGH -> o_e=0 the next cycle, o_ready=0, sequence restarts from 8'h38 after 20 cycles.
- DONE with i_d=8'hA5, i_rs=1, i_e=1 -> o_d=8'hA5, o_rs=1, o_e=1 one cycle later. With ST7066U_INIT_CURSOR_EN defined, third command = 8'h0F.
